// File: rtl/whack_pkg.sv
// Shared whack-a-mole definitions: geometry, game limits and session state.
// Imported by the judge, mole generator and score display.
package whack_pkg;

  localparam int N_HOLES    = 5;
  localparam int SCORE_MAX  = 999;
  localparam int MISS_LIMIT = 10;
  localparam int CNT_W      = $clog2(N_HOLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    OVER
  } game_state_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [N_HOLES-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < N_HOLES; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/press_edge.sv
// Rising-edge detector on the debounced buttons, split into hits and wrong
// presses against the mole mask, with a popcount of each.
module press_edge
  import whack_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [N_HOLES-1:0] button,
  input  logic [N_HOLES-1:0] mole,
  output logic [N_HOLES-1:0] hits,
  output logic [N_HOLES-1:0] wrong,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   wrong_cnt
);

  logic [N_HOLES-1:0] button_d;
  logic [N_HOLES-1:0] press;

  // Resetting to all ones means a button held through reset never fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      button_d <= '1;
    end else begin
      button_d <= button;
    end
  end

  assign press     = button & ~button_d;
  assign hits      = press & mole;
  assign wrong     = press & ~mole;
  assign hit_cnt   = popcount(hits);
  assign wrong_cnt = popcount(wrong);

endmodule

// File: rtl/hit_judge.sv
// Judges button presses against the mole mask, keeps score/miss/combo
// counters and runs the idle/play/over game session.
module hit_judge
  import whack_pkg::*;
#(
  parameter int SCORE_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_HOLES-1:0] button,
  input  logic [N_HOLES-1:0] mole,
  input  logic               start,
  input  logic               stop,
  output logic               hit_valid,
  output logic [N_HOLES-1:0] hit_clear,
  output logic               miss_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         misses,
  output logic [7:0]         combo,
  output logic [7:0]         best_combo,
  output logic               playing,
  output logic               game_over
);

  localparam int SUM_W = SCORE_W + 3;

  game_state_t        state;
  game_state_t        next_state;
  logic [N_HOLES-1:0] hits;
  logic [N_HOLES-1:0] wrong;
  logic [CNT_W-1:0]   hit_cnt;
  logic [CNT_W-1:0]   wrong_cnt;
  logic               judge;
  logic               hit_any;
  logic               wrong_any;
  logic [SUM_W-1:0]   score_sum;
  logic [SUM_W-1:0]   miss_sum;
  logic [SUM_W-1:0]   combo_sum;
  logic [SCORE_W-1:0] score_nx;
  logic [7:0]         misses_nx;
  logic [7:0]         combo_nx;
  logic [7:0]         best_nx;

  press_edge u_press_edge (
    .clk       (clk),
    .rst       (rst),
    .button    (button),
    .mole      (mole),
    .hits      (hits),
    .wrong     (wrong),
    .hit_cnt   (hit_cnt),
    .wrong_cnt (wrong_cnt)
  );

  // A start pulse restarts the session and swallows any press in its cycle.
  assign judge     = (state == PLAY) && !start;
  assign hit_any   = |hits;
  assign wrong_any = |wrong;

  assign score_sum = SUM_W'(score) + SUM_W'(hit_cnt);
  assign miss_sum  = SUM_W'(misses) + SUM_W'(wrong_cnt);
  assign combo_sum = SUM_W'(combo) + SUM_W'(hit_cnt);

  assign score_nx  = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                     : score_sum[SCORE_W-1:0];
  assign misses_nx = (miss_sum > SUM_W'(255)) ? 8'hFF : miss_sum[7:0];
  assign combo_nx  = wrong_any ? 8'd0
                   : ((combo_sum > SUM_W'(255)) ? 8'hFF : combo_sum[7:0]);
  assign best_nx   = (combo_nx > best_combo) ? combo_nx : best_combo;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = PLAY;
      PLAY: begin
        if (start) begin
          next_state = PLAY;
        end else if (stop || (misses_nx >= 8'(MISS_LIMIT))) begin
          next_state = OVER;
        end
      end
      OVER: if (start) next_state = PLAY;
      default: next_state = IDLE;
    endcase
  end

  // Status flags are registered from next_state so they land with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_valid  <= 1'b0;
      hit_clear  <= '0;
      miss_pulse <= 1'b0;
      score      <= '0;
      misses     <= '0;
      combo      <= '0;
      best_combo <= '0;
      playing    <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      hit_valid  <= judge && hit_any;
      hit_clear  <= judge ? hits : '0;
      miss_pulse <= judge && wrong_any;
      playing    <= (next_state == PLAY);
      game_over  <= (next_state == OVER);
      if (start) begin
        score  <= '0;
        misses <= '0;
        combo  <= '0;
      end else if (judge) begin
        score      <= score_nx;
        misses     <= misses_nx;
        combo      <= combo_nx;
        best_combo <= best_nx;
      end
    end
  end

endmodule

// File: tb/tb_hit_judge.sv
// Directed, table-driven check of hit_judge: edge detect, judgement,
// combo tracking, saturation, miss limit, start/stop priority and reset.
module tb_hit_judge;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] button;
  logic [4:0] mole;
  logic       start;
  logic       stop;
  logic       hit_valid;
  logic [4:0] hit_clear;
  logic       miss_pulse;
  logic [9:0] score;
  logic [7:0] misses;
  logic [7:0] combo;
  logic [7:0] best_combo;
  logic       playing;
  logic       game_over;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0] button;
    logic [4:0] mole;
    logic       start;
    logic       stop;
    logic       hv;
    logic [4:0] hc;
    logic       mp;
    int         score;
    int         misses;
    int         combo;
    int         best;
    logic       play;
    logic       over;
  } vec_t;

  vec_t vecs[$];

  hit_judge dut (
    .clk        (clk),
    .rst        (rst),
    .button     (button),
    .mole       (mole),
    .start      (start),
    .stop       (stop),
    .hit_valid  (hit_valid),
    .hit_clear  (hit_clear),
    .miss_pulse (miss_pulse),
    .score      (score),
    .misses     (misses),
    .combo      (combo),
    .best_combo (best_combo),
    .playing    (playing),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  task automatic addVec(input logic [4:0] b, input logic [4:0] m, input logic st,
                        input logic sp, input logic hv, input logic [4:0] hc,
                        input logic mp, input int sc, input int mi, input int co,
                        input int be, input logic pl, input logic ov);
    vec_t v;
    v.button = b;  v.mole = m;    v.start = st; v.stop = sp;
    v.hv = hv;     v.hc = hc;     v.mp = mp;    v.score = sc;
    v.misses = mi; v.combo = co;  v.best = be;  v.play = pl; v.over = ov;
    vecs.push_back(v);
  endtask

  // Drive inputs, take one rising edge, then settle before sampling.
  task automatic applyStimulus(input logic [4:0] b, input logic [4:0] m,
                               input logic st, input logic sp);
    button = b;
    mole   = m;
    start  = st;
    stop   = sp;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkVec(input string tag, input vec_t v);
    checkOutput({tag, ".hit_valid"},  32'(hit_valid),  32'(v.hv));
    checkOutput({tag, ".hit_clear"},  32'(hit_clear),  32'(v.hc));
    checkOutput({tag, ".miss_pulse"}, 32'(miss_pulse), 32'(v.mp));
    checkOutput({tag, ".score"},      32'(score),      v.score);
    checkOutput({tag, ".misses"},     32'(misses),     v.misses);
    checkOutput({tag, ".combo"},      32'(combo),      v.combo);
    checkOutput({tag, ".best_combo"}, 32'(best_combo), v.best);
    checkOutput({tag, ".playing"},    32'(playing),    32'(v.play));
    checkOutput({tag, ".game_over"},  32'(game_over),  32'(v.over));
  endtask

  initial begin
    // Held button through reset and into start must not fire.
    addVec(5'b00100, 5'b00100, 1, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 1, 0);
    addVec(5'b00100, 5'b00100, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 1, 0);
    addVec(5'b00000, 5'b00100, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 1, 0);
    addVec(5'b00100, 5'b00100, 0, 0, 1, 5'b00100, 0, 1, 0, 1, 1, 1, 0);
    addVec(5'b00000, 5'b10010, 0, 0, 0, 5'b00000, 0, 1, 0, 1, 1, 1, 0);
    // Two hits plus one wrong in the same cycle.
    addVec(5'b10011, 5'b10010, 0, 0, 1, 5'b10010, 1, 3, 1, 0, 1, 1, 0);
    addVec(5'b00000, 5'b10010, 0, 0, 0, 5'b00000, 0, 3, 1, 0, 1, 1, 0);
    addVec(5'b00000, 5'b00001, 1, 0, 0, 5'b00000, 0, 0, 0, 0, 1, 1, 0);
    for (int k = 1; k <= 5; k++) begin
      addVec(5'b00001, 5'b00001, 0, 0, 1, 5'b00001, 0, k, 0, k, k, 1, 0);
      addVec(5'b00000, 5'b00001, 0, 0, 0, 5'b00000, 0, k, 0, k, k, 1, 0);
    end
    addVec(5'b00010, 5'b00001, 0, 0, 0, 5'b00000, 1, 5, 1, 0, 5, 1, 0);
    addVec(5'b00000, 5'b00001, 0, 0, 0, 5'b00000, 0, 5, 1, 0, 5, 1, 0);
    addVec(5'b00000, 5'b00001, 1, 0, 0, 5'b00000, 0, 0, 0, 0, 5, 1, 0);
    addVec(5'b00100, 5'b00100, 0, 0, 1, 5'b00100, 0, 1, 0, 1, 5, 1, 0);
    addVec(5'b00000, 5'b00100, 0, 0, 0, 5'b00000, 0, 1, 0, 1, 5, 1, 0);
    // start + stop + valid hit: start wins, press swallowed.
    addVec(5'b00001, 5'b00001, 1, 1, 0, 5'b00000, 0, 0, 0, 0, 5, 1, 0);
    addVec(5'b00000, 5'b00001, 0, 0, 0, 5'b00000, 0, 0, 0, 0, 5, 1, 0);
    // stop with a press: press judged, then OVER.
    addVec(5'b00010, 5'b00010, 0, 1, 1, 5'b00010, 0, 1, 0, 1, 5, 0, 1);
    addVec(5'b00000, 5'b00010, 0, 0, 0, 5'b00000, 0, 1, 0, 1, 5, 0, 1);
    addVec(5'b00010, 5'b00010, 0, 0, 0, 5'b00000, 0, 1, 0, 1, 5, 0, 1);
    addVec(5'b00000, 5'b00010, 0, 0, 0, 5'b00000, 0, 1, 0, 1, 5, 0, 1);
    addVec(5'b00001, 5'b00010, 0, 0, 0, 5'b00000, 0, 1, 0, 1, 5, 0, 1);
    addVec(5'b00000, 5'b00000, 1, 0, 0, 5'b00000, 0, 0, 0, 0, 5, 1, 0);

    rst = 1'b1;
    applyStimulus(5'b00100, 5'b00000, 0, 0);
    applyStimulus(5'b00100, 5'b00000, 0, 0);
    checkVec("reset", '{5'b0, 5'b0, 0, 0, 0, 5'b0, 0, 0, 0, 0, 0, 0, 0});
    rst = 1'b0;
    applyStimulus(5'b00100, 5'b00000, 0, 0);
    checkVec("idle_hold", '{5'b0, 5'b0, 0, 0, 0, 5'b0, 0, 0, 0, 0, 0, 0, 0});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].button, vecs[i].mole, vecs[i].start, vecs[i].stop);
      checkVec($sformatf("v%0d", i), vecs[i]);
    end

    // Score saturation: 199 five-mole presses + a three-mole press = 998.
    applyStimulus(5'b00000, 5'b11111, 1, 0);
    for (int i = 0; i < 199; i++) begin
      applyStimulus(5'b11111, 5'b11111, 0, 0);
      applyStimulus(5'b00000, 5'b11111, 0, 0);
    end
    applyStimulus(5'b00111, 5'b11111, 0, 0);
    checkOutput("sat.score998", 32'(score), 998);
    checkOutput("sat.combo255", 32'(combo), 255);
    applyStimulus(5'b00000, 5'b00011, 0, 0);
    applyStimulus(5'b00011, 5'b00011, 0, 0);
    checkOutput("sat.score999", 32'(score), 999);
    checkOutput("sat.hit_clear", 32'(hit_clear), 32'(5'b00011));
    applyStimulus(5'b00000, 5'b11111, 0, 0);
    applyStimulus(5'b11111, 5'b11111, 0, 0);
    checkOutput("sat.score_hold", 32'(score), 999);
    checkOutput("sat.hit_valid", 32'(hit_valid), 1);

    // Miss limit ends the game the cycle after the tenth wrong press.
    applyStimulus(5'b00000, 5'b00000, 1, 0);
    checkOutput("miss.start_score", 32'(score), 0);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(5'b00001, 5'b00000, 0, 0);
      checkOutput($sformatf("miss.count%0d", i), 32'(misses), i);
      checkOutput($sformatf("miss.over%0d", i), 32'(game_over), (i == 10) ? 1 : 0);
      applyStimulus(5'b00000, 5'b00000, 0, 0);
    end
    checkOutput("miss.playing", 32'(playing), 0);
    applyStimulus(5'b00010, 5'b00000, 0, 0);
    checkOutput("miss.over_hold", 32'(misses), 10);
    checkOutput("miss.over_pulse", 32'(miss_pulse), 0);
    applyStimulus(5'b00000, 5'b00000, 1, 0);
    checkOutput("miss.restart_play", 32'(playing), 1);
    checkOutput("miss.restart_misses", 32'(misses), 0);
    checkOutput("miss.restart_over", 32'(game_over), 0);

    // Reset mid-game with a press in flight.
    applyStimulus(5'b00001, 5'b00001, 0, 0);
    checkOutput("rst.pre_score", 32'(score), 1);
    applyStimulus(5'b00000, 5'b00001, 0, 0);
    rst = 1'b1;
    applyStimulus(5'b00001, 5'b00001, 0, 0);
    checkVec("rst_mid", '{5'b0, 5'b0, 0, 0, 0, 5'b0, 0, 0, 0, 0, 0, 0, 0});
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hit_judge.md
# hit_judge

Consumes the five debounced, level-stable button lines produced by the debounce stage and judges each new press against the current mole mask. Counts hits, misses and combos, emits a one-cycle clear mask back to the mole generator, and owns the game-session state (idle / play / over). All outputs are registered, so the score display and mole logic read clean, synchronous values.

## Interface
- N_HOLES, 5, number of holes and buttons
- SCORE_W, 10, score counter width
- SCORE_MAX, 999, score saturation value
- MISS_LIMIT, 10, misses that end a game
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- button  in  N_HOLES  debounced button levels, 1 = pressed
- mole  in  N_HOLES  mole-up mask from the mole generator
- start  in  1  one-cycle pulse: begin a new game
- stop  in  1  one-cycle pulse: end the game (timer expiry)
- hit_valid  out  1  one-cycle pulse: at least one hit this cycle
- hit_clear  out  N_HOLES  one-cycle mask of holes hit; the mole generator drops them
- miss_pulse  out  1  one-cycle pulse: at least one wrong press
- score  out  SCORE_W  hits this game, saturating
- misses  out  8  wrong presses this game, saturating at 255
- combo  out  8  consecutive hits since the last miss, saturating at 255
- best_combo  out  8  maximum combo since reset
- playing  out  1  state == PLAY
- game_over  out  1  state == OVER

## Operation
- Edge detect: `press = button & ~button_d`. `button_d` updates every cycle in every state; reset value is all ones, so a button held through reset never fires.
- Per-cycle judgement, PLAY only:
  - `hits = press & mole`
  - `wrong = press & ~mole`
  - Both may be nonzero in the same cycle.
- On `hits != 0`:
  - `score += popcount(hits)`, clamped at SCORE_MAX.
  - `hit_clear <= hits`; `hit_valid <= 1`.
- On `wrong != 0`:
  - `misses += popcount(wrong)`, clamped at 255.
  - `miss_pulse <= 1`.
- Combo update:
  - `combo <= (wrong != 0) ? 0 : sat255(combo + popcount(hits))`. A miss in the same cycle as a hit zeroes combo; the hit still scores.
  - `best_combo <= max(best_combo, next combo)`.
- State machine (reset → IDLE):
  - IDLE: presses ignored. `start` → PLAY.
  - PLAY: `start` → PLAY again; counters cleared, `best_combo` kept. `stop` → OVER. Next `misses >= MISS_LIMIT` → OVER.
  - OVER: presses ignored, counters hold. `start` → PLAY.
- Start clearing: `start` clears `score`, `misses` and `combo`, and suppresses judgement in that cycle, including any press.
- Simultaneous events:
  - `start` and `stop` together: `start` wins.
  - In PLAY, `stop` with a press: the press is still judged in that cycle, then the state goes to OVER.
- Pulses are forced low outside PLAY.
- Popcount is on N_HOLES bits. Sums are computed in SCORE_W+3 bits before clamping, so nothing wraps.

## Timing
- All outputs registered. Press edge visible on `button` at rising edge N → `hit_valid`, `hit_clear`, `score` updated at edge N+1.
- `hit_valid`, `hit_clear` and `miss_pulse` are high for exactly one cycle per judged edge. A held button produces no further pulses.
- State changes take effect at the edge after `start`, `stop` or the miss limit. `playing` and `game_over` follow with the same latency.
- Reset values (rst sampled high at an edge):
  - state = IDLE; `button_d` = all ones.
  - All counters, `best_combo`, pulses and `hit_clear` = 0.
  - `playing` = `game_over` = 0.
- Reset asserted mid-game aborts everything at the next edge, with no partial updates.

## Structure
- Shared package `whack_pkg`: N_HOLES, SCORE_MAX, MISS_LIMIT and `game_state_t` {IDLE, PLAY, OVER}. The mole generator and score display also import it.
- One sub-module: `press_edge` (N_HOLES-wide rising-edge detector plus popcount). Judge, counters and FSM live in `hit_judge`.

## Test plan
- Reset with `button` = 5'b00100 held, then release and re-press → no pulse during hold; after `start`, the re-press with `mole` = 5'b00100 gives `hit_clear` = 5'b00100 one cycle later and `score` = 1.
- In PLAY, `mole` = 5'b10010, `button` rising 5'b00000 → 5'b10011 in one cycle → `hit_clear` = 5'b10010, `score` +2, `misses` +1, `combo` = 0, both pulses high for one cycle.
- Five single hits, then one wrong press → `combo` steps 1..5 then 0; `best_combo` = 5; `best_combo` still 5 after a new `start`.
- Preload `score` to 998, press two moles at once → `score` = 999 and stays there on further hits.
- 10 wrong presses → `game_over` = 1 the cycle after the 10th; further presses change nothing; `start` → `playing` = 1, counters 0.
- `start` and `stop` in the same cycle as a valid hit → state PLAY, `score` 0, no `hit_valid`. Assert `rst` mid-game → all outputs at reset values on the next edge.
